// File: rtl/frame_downsampler_pkg.sv
// Shared frame-buffer geometry, downsampler state encoding and output beat type.
package frame_downsampler_pkg;

    localparam int unsigned COL_NUM         = 320;
    localparam int unsigned ROW_NUM         = 240;
    localparam int unsigned PIXEL_NUM       = COL_NUM * ROW_NUM;
    localparam int unsigned PIXEL_NUM_WIDTH = $clog2(PIXEL_NUM);
    localparam int unsigned CROP_X          = 48;
    localparam int unsigned CROP_Y          = 8;
    localparam int unsigned BLOCK           = 8;
    localparam int unsigned OUT_DIM         = 28;
    localparam int unsigned CROP_DIM        = OUT_DIM * BLOCK;
    localparam int unsigned CROP_BASE       = CROP_Y * COL_NUM + CROP_X;

    localparam int unsigned BLOCK_W = $clog2(BLOCK);
    localparam int unsigned COL_W   = $clog2(CROP_DIM);
    localparam int unsigned SEL_W   = $clog2(OUT_DIM);
    localparam int unsigned CNT_W   = $clog2(BLOCK * BLOCK) + 1;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned IDX_W   = $clog2(OUT_DIM * OUT_DIM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } ds_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [PIX_W-1:0] data;
    } pix_beat_t;

    // Map a white-pixel count (0..64) onto 8-bit gray; a full block saturates to 255.
    function automatic logic [PIX_W-1:0] count_to_gray(input logic [CNT_W-1:0] count);
        if (count == CNT_W'(BLOCK * BLOCK)) begin
            return PIX_W'(255);
        end
        return {count[CNT_W-2:0], 2'b00};
    endfunction

endpackage

// File: rtl/frame_downsampler_if.sv
// Output pixel stream from the downsampler to the classifier input buffer.
interface frame_downsampler_if;
    import frame_downsampler_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic [IDX_W-1:0] out_index;

    modport master (output out_valid, output out_data, output out_index, input out_ready);
    modport slave  (input out_valid, input out_data, input out_index, output out_ready);

endinterface

// File: rtl/frame_downsampler_block_accumulator.sv
// Bank of per-block white-pixel counters for one block row.
module block_accumulator
    import frame_downsampler_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc_en,
    input  logic [SEL_W-1:0] inc_sel,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_count
);

    logic [CNT_W-1:0] acc [OUT_DIM];

    // Counter bank: clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(OUT_DIM); i++) begin
                acc[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(OUT_DIM); i++) begin
                acc[i] <= '0;
            end
        end else if (inc_en) begin
            acc[inc_sel] <= acc[inc_sel] + CNT_W'(1);
        end
    end

    assign rd_count = (rd_sel < SEL_W'(OUT_DIM)) ? acc[rd_sel] : '0;

endmodule

// File: rtl/frame_downsampler.sv
// Scans the 224x224 crop of the 1-bit frame buffer and streams a 28x28 gray image.
module frame_downsampler
    import frame_downsampler_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [PIXEL_NUM_WIDTH-1:0] ram_read_addr,
    input  logic                       ram_q,
    frame_downsampler_if.master        pix
);

    ds_state_t                  state_q, state_nx;
    logic [SEL_W-1:0]           brow_q, brow_nx;
    logic [BLOCK_W-1:0]         line_q, line_nx;
    logic [COL_W-1:0]           col_q, col_nx;
    logic [PIXEL_NUM_WIDTH-1:0] row_base_q, row_base_nx;
    logic [PIXEL_NUM_WIDTH-1:0] addr_q, addr_nx;
    logic                       tag_vld_q, tag_vld_nx;
    logic [COL_W-1:0]           tag_col_q, tag_col_nx;
    logic [SEL_W-1:0]           k_q, k_nx;
    pix_beat_t                  beat_q, beat_nx;
    logic                       out_valid_q, out_valid_nx;
    logic                       busy_q, busy_nx;
    logic                       done_q, done_nx;
    logic                       q_hold_q, hold_q;
    logic                       q_eff;
    logic                       acc_clear;
    logic [SEL_W-1:0]           rd_sel;
    logic [CNT_W-1:0]           rd_count;

    // While stalled the RAM re-reads the held address, so park the in-flight datum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_hold_q <= 1'b0;
            hold_q   <= 1'b0;
        end else if (!en) begin
            if (!hold_q) begin
                q_hold_q <= ram_q;
                hold_q   <= 1'b1;
            end
        end else begin
            hold_q <= 1'b0;
        end
    end

    assign q_eff = hold_q ? q_hold_q : ram_q;

    block_accumulator u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (en && acc_clear),
        .inc_en   (en && tag_vld_q && q_eff),
        .inc_sel  (tag_col_q[COL_W-1:BLOCK_W]),
        .rd_sel   (rd_sel),
        .rd_count (rd_count)
    );

    // Next-state, address generation and output beat selection.
    always_comb begin
        state_nx    = state_q;
        brow_nx     = brow_q;
        line_nx     = line_q;
        col_nx      = col_q;
        row_base_nx = row_base_q;
        addr_nx     = addr_q;
        tag_vld_nx  = 1'b0;
        tag_col_nx  = tag_col_q;
        k_nx        = k_q;
        beat_nx     = beat_q;
        acc_clear   = 1'b0;
        rd_sel      = k_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nx    = ST_READ;
                    brow_nx     = '0;
                    line_nx     = '0;
                    col_nx      = '0;
                    row_base_nx = PIXEL_NUM_WIDTH'(CROP_BASE);
                    addr_nx     = PIXEL_NUM_WIDTH'(CROP_BASE);
                    beat_nx     = '0;
                    acc_clear   = 1'b1;
                end
            end
            ST_READ: begin
                tag_vld_nx = 1'b1;
                tag_col_nx = col_q;
                if (col_q == COL_W'(CROP_DIM - 1)) begin
                    col_nx = '0;
                    if (line_q == BLOCK_W'(BLOCK - 1)) begin
                        state_nx = ST_DRAIN;
                    end else begin
                        line_nx     = line_q + BLOCK_W'(1);
                        row_base_nx = row_base_q + PIXEL_NUM_WIDTH'(COL_NUM);
                        addr_nx     = row_base_q + PIXEL_NUM_WIDTH'(COL_NUM);
                    end
                end else begin
                    col_nx  = col_q + COL_W'(1);
                    addr_nx = addr_q + PIXEL_NUM_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                state_nx     = ST_EMIT;
                k_nx         = '0;
                rd_sel       = '0;
                beat_nx.data = count_to_gray(rd_count);
            end
            ST_EMIT: begin
                if (pix.out_ready) begin
                    beat_nx.index = beat_q.index + IDX_W'(1);
                    if (k_q == SEL_W'(OUT_DIM - 1)) begin
                        acc_clear = 1'b1;
                        if (brow_q == SEL_W'(OUT_DIM - 1)) begin
                            state_nx = ST_DONE;
                        end else begin
                            state_nx    = ST_READ;
                            brow_nx     = brow_q + SEL_W'(1);
                            line_nx     = '0;
                            col_nx      = '0;
                            row_base_nx = row_base_q + PIXEL_NUM_WIDTH'(COL_NUM);
                            addr_nx     = row_base_q + PIXEL_NUM_WIDTH'(COL_NUM);
                        end
                    end else begin
                        k_nx         = k_q + SEL_W'(1);
                        rd_sel       = k_q + SEL_W'(1);
                        beat_nx.data = count_to_gray(rd_count);
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        out_valid_nx = (state_nx == ST_EMIT);
        busy_nx      = (state_nx != ST_IDLE);
        done_nx      = (state_nx == ST_DONE);
    end

    // State and output registers; everything freezes while en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            brow_q      <= '0;
            line_q      <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            addr_q      <= '0;
            tag_vld_q   <= 1'b0;
            tag_col_q   <= '0;
            k_q         <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (en) begin
            state_q     <= state_nx;
            brow_q      <= brow_nx;
            line_q      <= line_nx;
            col_q       <= col_nx;
            row_base_q  <= row_base_nx;
            addr_q      <= addr_nx;
            tag_vld_q   <= tag_vld_nx;
            tag_col_q   <= tag_col_nx;
            k_q         <= k_nx;
            beat_q      <= beat_nx;
            out_valid_q <= out_valid_nx;
            busy_q      <= busy_nx;
            done_q      <= done_nx;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign ram_read_addr = addr_q;
    assign pix.out_valid = out_valid_q;
    assign pix.out_data  = beat_q.data;
    assign pix.out_index = beat_q.index;

endmodule

// File: tb/tb_frame_downsampler.sv
// Scoreboard bench: composite test frame, stalled run aborted by reset, then a clean full run.
module tb_frame_downsampler;
    import frame_downsampler_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic start;
    logic busy;
    logic done;
    logic ram_q = 1'b0;
    logic [PIXEL_NUM_WIDTH-1:0] ram_read_addr;

    frame_downsampler_if pif();

    frame_downsampler dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .ram_read_addr (ram_read_addr),
        .ram_q         (ram_q),
        .pix           (pif)
    );

    always #5 clk = ~clk;

    bit        frame [PIXEL_NUM];
    pix_beat_t sb_q[$];
    int        n_checks = 0;
    int        n_fail = 0;
    int        beats_seen = 0;
    int        addr_viol = 0;
    int        edge_cnt = 0;
    int        start_edge = 0;
    bit        hold_pend = 0;
    pix_beat_t held;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Test image: outside crop white; block rows carry single pixels, white, checker, black.
    function automatic bit pixel_of(input int x, input int y);
        int br;
        if (x < 48 || x > 271 || y < 8 || y > 231) return 1'b1;
        br = (y - 8) / 8;
        if (br == 0) return (x == 48 && y == 8) || (x >= 88 && x <= 95 && !(x == 95 && y == 15));
        if (br == 1 || br == 2 || (br >= 5 && br <= 9)) return 1'b1;
        if (br == 3 || br == 4 || (br >= 10 && br <= 19)) return ((x + y) % 2) == 0;
        if (br <= 26) return 1'b0;
        return (x == 271 && y == 231);
    endfunction

    // Hand-derived gray values per output index for the test image.
    function automatic int exp_data(input int i);
        int r;
        int c;
        r = i / 28;
        c = i % 28;
        if (r == 0) return (c == 0) ? 4 : ((c == 5) ? 252 : 0);
        if (r == 1 || r == 2 || (r >= 5 && r <= 9)) return 255;
        if (r == 3 || r == 4 || (r >= 10 && r <= 19)) return 128;
        if (r <= 26) return 0;
        return (c == 27) ? 4 : 0;
    endfunction

    task automatic push_expected();
        pix_beat_t b;
        for (int i = 0; i < 784; i++) begin
            b.index = IDX_W'(i);
            b.data  = PIX_W'(exp_data(i));
            sb_q.push_back(b);
        end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        en = 1'b1;
        start = 1'b1;
        start_edge = edge_cnt + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    always @(posedge clk) edge_cnt++;

    // Synchronous-read frame buffer.
    always @(posedge clk) ram_q <= frame[ram_read_addr];

    // Flags any read outside the crop while a conversion is running.
    always @(posedge clk) begin : addr_mon
        int a;
        a = int'(ram_read_addr);
        if (reset && busy && ((a / 320) < 8 || (a / 320) > 231 || (a % 320) < 48 || (a % 320) > 271))
            addr_viol++;
    end

    // Output monitor: pops on handshake, checks stability across stalls.
    always @(negedge clk) begin
        if (!reset) begin
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                check("stall_valid", pif.out_valid, 1);
                check("stall_data", pif.out_data, held.data);
                check("stall_index", pif.out_index, held.index);
            end
            hold_pend = 0;
            if (pif.out_valid) begin
                if (pif.out_ready && en) begin
                    beats_seen++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", pif.out_index, 1024);
                    end else begin
                        held = sb_q.pop_front();
                        check("beat_index", pif.out_index, held.index);
                        check("beat_data", pif.out_data, held.data);
                    end
                end else begin
                    hold_pend = 1;
                    held.data = pif.out_data;
                    held.index = pif.out_index;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, pif.out_valid, 0);
        check({tag, "_data"}, pif.out_data, 0);
        check({tag, "_index"}, pif.out_index, 0);
        check({tag, "_addr"}, ram_read_addr, 0);
    endtask

    initial begin
        int n;
        bit got;
        reset = 1'b1;
        en = 1'b1;
        start = 1'b0;
        pif.out_ready = 1'b1;
        for (int y = 0; y < int'(ROW_NUM); y++)
            for (int x = 0; x < int'(COL_NUM); x++)
                frame[y * int'(COL_NUM) + x] = pixel_of(x, y);
        #2 reset = 1'b0;
        #20;
        check_reset_values("por");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        // Run 1: random en/out_ready/start stalls, aborted by reset in block row 5.
        beats_seen = 0;
        push_expected();
        do_start();
        n = 0;
        while (beats_seen < 140 && n < 30000) begin
            @(posedge clk);
            #1;
            en = ($urandom_range(0, 7) != 0);
            pif.out_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
            n++;
        end
        check("abort_point_reached", (n < 30000) ? 1 : 0, 1);
        repeat (300) begin
            @(posedge clk);
            #1;
            en = ($urandom_range(0, 7) != 0);
            pif.out_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
        end
        check("beats_before_abort", beats_seen, 140);
        check("busy_mid_run", busy, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_reset_values("abort");
        start = 1'b0;
        en = 1'b1;
        pif.out_ready = 1'b1;
        sb_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        // Run 2: clean full conversion with exact completion timing.
        beats_seen = 0;
        push_expected();
        do_start();
        n = 0;
        got = 0;
        while (!got && n < 60000) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
        end
        check("done_seen", got, 1);
        check("done_cycle", edge_cnt - start_edge + 1, 50989);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("beats_total", beats_seen, 784);
        check("queue_empty", sb_q.size(), 0);
        check("addr_in_crop", addr_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_downsampler.md
Name: frame_downsampler

Overview:
Reader side of the LCD frame buffer that the touchscreen painter writes.
- Scans a fixed 224x224 crop of the 320x240 1-bit frame buffer, counts white pixels in each 8x8 block, and emits a 28x28 grayscale image (784 pixels, raster order) to the digit classifier.
- Sits between the frame buffer read port and the neural network input buffer.
- Started by the top-level controller after drawing ends.

Parameters:
- COL_NUM, 320, frame width in pixels
- ROW_NUM, 240, frame height in pixels
- PIXEL_NUM, 76800, frame size; PIXEL_NUM_WIDTH = $clog2(PIXEL_NUM) = 17
- CROP_X, 48, first cropped column
- CROP_Y, 8, first cropped row
- BLOCK, 8, block edge in pixels (power of two)
- OUT_DIM, 28, output image edge; crop edge = OUT_DIM*BLOCK = 224

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  clock enable; when low, all state, counters and outputs hold
- start  in  1  begin a conversion; sampled only in IDLE with en high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on conversion completion
- ram_read_addr  out  17  frame buffer read address
- ram_q  in  1  frame buffer data; synchronous read, valid 1 cycle after the address
- out_valid  out  1  out_data/out_index valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  8  grayscale pixel value
- out_index  out  10  pixel index 0..783 (row*28 + col)

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done=0, out_valid=0, out_data=0, out_index=0, ram_read_addr=0, all accumulators 0.
- States: IDLE, READ, DRAIN, EMIT, DONE.
- IDLE: start && en -> READ, clearing the counters (brow=0, line=0, col=0) and all 28 accumulators. start in any other state is ignored.
- READ: ram_read_addr = (CROP_Y + brow*BLOCK + line)*COL_NUM + CROP_X + col.
  - Form the address with a row-base register incremented by COL_NUM per line; no multiplier.
  - col counts 0..223, then line 0..7. One address per enabled cycle.
  - A 1-cycle delayed valid/column tag adds ram_q into accumulator[col_d >> 3].
  - After address (line=7, col=223) -> DRAIN.
- DRAIN: 1 cycle; absorbs the final read datum -> EMIT.
- EMIT: presents accumulator[k] for k=0..27.
  - out_index = brow*28 + k.
  - out_data = 255 if count==64, else count*4. Counts are 7-bit, 0..64.
  - k advances only on handshake. out_valid, out_data and out_index stay stable while out_ready is low.
  - After k=27 handshake: clear accumulators. brow<27 -> brow+1, READ; else -> DONE.
- DONE: done=1 for exactly one enabled cycle -> IDLE.
- out_valid is high only in EMIT.
- en low freezes the FSM and pipeline. ram_read_addr is held, so the RAM re-presents the same datum and no read is lost or duplicated.
- Timing with en=1 and out_ready=1: per block row, 1792 READ + 1 DRAIN + 28 EMIT = 1821 cycles. If start is sampled at edge 0, done is high in cycle 1 + 28*1821 = 50989.
- Reset mid-conversion aborts immediately to the reset values. No partial output is retained.
- Pixels outside the crop are never read.

Decomposition:
- Shared package/constants: COL_NUM, ROW_NUM, PIXEL_NUM, PIXEL_NUM_WIDTH, CROP_X, CROP_Y, BLOCK, OUT_DIM, and the state encodings. These are shared with the painter and the classifier input buffer.
- Sub-module: block_accumulator, the bank of 28 x 7-bit counters.
  - Ports: clear, inc_en, inc_sel[4:0], rd_sel[4:0], rd_count.
  - The FSM and address generation stay in frame_downsampler.

Test Plan:
- All-white frame, out_ready=1: 784 outputs, all out_data=255, out_index 0..783 in order. done at cycle 50989, busy low the cycle after.
- All-black frame: 784 outputs of 0; no reads outside addresses 8*320+48 .. 231*320+271.
- Single white pixel at (x=48, y=8): index 0 = 4, all others 0. Pixel at (271, 231): index 783 = 4. Pixel at (47, 8) or (272, 8): all outputs 0.
- Checkerboard (white when x+y even): every output = 128 (count 32).
- Random out_ready and en toggling on the all-white frame: identical 784-value sequence; data/index stable while stalled; no beat dropped or duplicated.
- reset low mid-READ (brow=5): outputs return to reset values asynchronously. A new start yields the correct full image beginning at index 0. start pulses while busy are ignored.
